seg7_scan_mux: RTL and testbench

Multiplexed driver for an N-digit common-anode seven-segment display. It is the parametrised successor of the single-digit decoder.
- Time-multiplexes N_DIGITS packed 4-bit digit values onto one shared segment bus and one anode per digit.
- Adds hex/decimal mode, decimal points, per-digit blank and blink, leading-zero suppression, and tear-free frame snapshotting.
- Sits between the application datapath (counters, scores) and the board display pins.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 15 +
 rtl/seg7_scan_mux.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_mux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment types and glyph table for the multiplexed seven-segment driver.
// Segment order is {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  localparam seg_t GLYPH [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder; in decimal mode values above 9 are blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       hex_en_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = GLYPH[value_i];
    if (!hex_en_i && (value_i > 4'd9)) seg_o = SEG_OFF;
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit common-anode scan driver: prescaled digit rotation, per-frame input
// snapshot, blink, leading-zero suppression, registered glitch-free outputs.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic [N_DIGITS-1:0]   blink_i,
  input  logic                  lz_en_i,
  input  logic                  hex_en_i,
  output seg_t                  seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o
);

  localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_ph_q, blink_ph_d;

  logic [4*N_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [N_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [N_DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic                  sh_lz_q, sh_lz_d;
  logic                  sh_hex_q, sh_hex_d;
  logic                  sh_ph_q, sh_ph_d;

  logic [N_DIGITS-1:0]   an_q, an_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  frame_start;
  logic [3:0]            value;
  seg_t                  glyph;
  logic                  dark;
  logic [N_DIGITS-1:0]   lz_sup;

  always_comb begin
    frame_start = (presc_q == '0) && (idx_q == '0);

    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (frame_start) begin
      if (blink_cnt_q + 1'b1 == BLINK_W'(BLINK_FRAMES)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // The frame shows the blink phase that was in effect when it began.
    sh_digits_d = frame_start ? digits_i   : sh_digits_q;
    sh_dp_d     = frame_start ? dp_i       : sh_dp_q;
    sh_blank_d  = frame_start ? blank_i    : sh_blank_q;
    sh_blink_d  = frame_start ? blink_i    : sh_blink_q;
    sh_lz_d     = frame_start ? lz_en_i    : sh_lz_q;
    sh_hex_d    = frame_start ? hex_en_i   : sh_hex_q;
    sh_ph_d     = frame_start ? blink_ph_q : sh_ph_q;

    frame_d = frame_start;
  end

  always_comb begin
    logic all_zero;
    lz_sup   = '0;
    all_zero = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      all_zero  = all_zero && (sh_digits_d[4*k +: 4] == 4'd0);
      lz_sup[k] = sh_lz_d && all_zero;
    end
  end

  seg7_decode u_decode (
    .value_i  (value),
    .hex_en_i (sh_hex_d),
    .seg_o    (glyph)
  );

  always_comb begin
    value = sh_digits_d[{idx_q, 2'b00} +: 4];
    dark  = sh_blank_d[idx_q]
          | (sh_blink_d[idx_q] & sh_ph_d)
          | lz_sup[idx_q]
          | (!sh_hex_d && (value > 4'd9));
    an_d  = dark ? '1 : ~(N_DIGITS'(1) << idx_q);
    seg_d = dark ? SEG_OFF : glyph;
    dp_d  = dark ? 1'b1 : ~sh_dp_d[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_blink_q  <= '0;
      sh_lz_q     <= 1'b0;
      sh_hex_q    <= 1'b0;
      sh_ph_q     <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      sh_digits_q <= sh_digits_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      sh_blink_q  <= sh_blink_d;
      sh_lz_q     <= sh_lz_d;
      sh_hex_q    <= sh_hex_d;
      sh_ph_q     <= sh_ph_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      frame_q     <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_seg7_scan_mux;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GF = 7'b0001110;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_i;
  logic [3:0]  dp_i, blank_i, blink_i;
  logic        lz_en_i, hex_en_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   fs     = 0;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_mux #(.N_DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .digits_i (digits_i),
    .dp_i     (dp_i),
    .blank_i  (blank_i),
    .blink_i  (blink_i),
    .lz_en_i  (lz_en_i),
    .hex_en_i (hex_en_i),
    .seg_o    (seg_o),
    .dp_o     (dp_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL missed_entry cyc=%0d now=%0d", e.cyc, cyc);
      end else if ({an_o, seg_o, dp_o, frame_o} !== {e.an, e.seg, e.dp, e.frame}) begin
        errors++;
        $display("FAIL outputs cyc=%0d got an=%b seg=%b dp=%b fr=%b exp an=%b seg=%b dp=%b fr=%b",
                 cyc, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.frame);
      end
    end
  end

  task automatic push_dark(input int c);
    exp_t e;
    e.cyc = c; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.frame = 1'b0;
    sb.push_back(e);
  endtask

  // lit: which digits are visible; segs: {d3,d2,d1,d0} glyphs; dps: dp_o when lit
  task automatic push_frame(input logic [3:0] lit, input logic [27:0] segs,
                            input logic [3:0] dps, input int n);
    exp_t e;
    for (int t = 0; t < n; t++) begin
      int d;
      d = t / 4;
      e.cyc   = fs + t;
      e.frame = (t == 0);
      if (lit[d]) begin
        e.an  = 4'hF ^ (4'b0001 << d);
        e.seg = segs[7*d +: 7];
        e.dp  = dps[d];
      end else begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end
      sb.push_back(e);
    end
    fs += 16;
  endtask

  task automatic wait_to(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_frame(input logic [3:0] lit, input logic [27:0] segs, input logic [3:0] dps);
    push_frame(lit, segs, dps, 16);
    wait_to(fs - 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int fs0;
    rst = 1'b1; digits_i = '0; dp_i = '0; blank_i = '0; blink_i = '0;
    lz_en_i = 1'b0; hex_en_i = 1'b0;
    @(negedge clk);
    push_dark(cyc + 1);
    @(negedge clk);

    // scan order
    digits_i = 16'h1234;
    rst = 1'b0;
    fs = cyc + 1;
    run_frame(4'hF, {G1, G2, G3, G4}, 4'hF);
    run_frame(4'hF, {G1, G2, G3, G4}, 4'hF);

    // hex then decimal
    digits_i = 16'hABCF; hex_en_i = 1'b1;
    run_frame(4'hF, {GA, GB, GC, GF}, 4'hF);
    hex_en_i = 1'b0;
    run_frame(4'h0, 28'h0, 4'hF);

    // leading zeros
    digits_i = 16'h0070; lz_en_i = 1'b1;
    run_frame(4'b0011, {G0, G0, G7, G0}, 4'hF);
    digits_i = 16'h0000;
    run_frame(4'b0001, {G0, G0, G0, G0}, 4'hF);

    // snapshot: change inputs while digit 2 is shown
    lz_en_i = 1'b0; digits_i = 16'h1111;
    run_frame(4'hF, {G1, G1, G1, G1}, 4'hF);
    push_frame(4'hF, {G1, G1, G1, G1}, 4'hF, 16);
    wait_to(fs - 16 + 9);
    digits_i = 16'h2222;
    wait_to(fs - 2);
    run_frame(4'hF, {G2, G2, G2, G2}, 4'hF);

    // reset while digit 3 is being driven
    fs0 = fs;
    push_frame(4'hF, {G2, G2, G2, G2}, 4'hF, 13);
    wait_to(fs0 + 12);
    rst = 1'b1;
    digits_i = 16'h5678; blink_i = 4'b0001; dp_i = 4'b0010; blank_i = 4'b1000;
    push_dark(fs0 + 13);
    @(negedge clk);
    rst = 1'b0;
    fs = fs0 + 14;

    // blink / dp / blank: digit 0 lit 2 frames, dark 2 frames
    run_frame(4'b0111, {G5, G6, G7, G8}, 4'b1101);
    run_frame(4'b0111, {G5, G6, G7, G8}, 4'b1101);
    run_frame(4'b0110, {G5, G6, G7, G8}, 4'b1101);
    run_frame(4'b0110, {G5, G6, G7, G8}, 4'b1101);
    run_frame(4'b0111, {G5, G6, G7, G8}, 4'b1101);
    run_frame(4'b0111, {G5, G6, G7, G8}, 4'b1101);
    run_frame(4'b0110, {G5, G6, G7, G8}, 4'b1101);

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
